seq_accum_core: RTL and testbench

//  Parametrised multi-cycle accumulator CPU: successor of the single-cycle RON/IR datapath.

---
 rtl/seq_accum_pkg.sv | 58 +++++
 rtl/seq_accum_if.sv | 27 ++
 rtl/seq_accum_alu.sv | 19 +
 rtl/seq_accum_core.sv | 114 +++++++++++
 tb/tb_seq_accum_core.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_accum_pkg.sv
// seq_accum_pkg: opcodes, FSM states and instruction decode shared by the accumulator core.
package seq_accum_pkg;

    localparam logic [7:0] OP_ST    = 8'h00;
    localparam logic [7:0] OP_SETIR = 8'h02;
    localparam logic [7:0] OP_LD    = 8'h11;
    localparam logic [7:0] OP_LDI   = 8'h15;
    localparam logic [7:0] OP_ADD   = 8'h21;
    localparam logic [7:0] OP_ADDI  = 8'h25;
    localparam logic [7:0] OP_SUB   = 8'h31;
    localparam logic [7:0] OP_SUBI  = 8'h35;
    localparam logic [7:0] OP_JZ    = 8'hF0;
    localparam logic [7:0] OP_JNZ   = 8'hF1;
    localparam logic [7:0] OP_JGT   = 8'hF2;
    localparam logic [7:0] OP_JLT   = 8'hF3;
    localparam logic [7:0] OP_JMP   = 8'hFE;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
    typedef enum logic [1:0] {ALU_PASS, ALU_ADD, ALU_SUB} aluMode_t;
    typedef enum logic [2:0] {J_NONE, J_Z, J_NZ, J_GT, J_LT, J_ALWAYS} jumpCond_t;

    typedef struct packed {
        logic      legal;
        logic      memOp;
        logic      memWrite;
        logic      accWrite;
        logic      irWrite;
        logic      halt;
        aluMode_t  aluMode;
        jumpCond_t jump;
    } decode_t;

    function automatic decode_t decodeOp(input logic [7:0] op);
        decode_t d;
        d = '0;
        d.legal = 1'b1;
        case (op)
            OP_ST:    begin d.memOp = 1'b1; d.memWrite = 1'b1; end
            OP_SETIR: d.irWrite = 1'b1;
            OP_LD:    begin d.memOp = 1'b1; d.accWrite = 1'b1; end
            OP_LDI:   d.accWrite = 1'b1;
            OP_ADD:   begin d.memOp = 1'b1; d.accWrite = 1'b1; d.aluMode = ALU_ADD; end
            OP_ADDI:  begin d.accWrite = 1'b1; d.aluMode = ALU_ADD; end
            OP_SUB:   begin d.memOp = 1'b1; d.accWrite = 1'b1; d.aluMode = ALU_SUB; end
            OP_SUBI:  begin d.accWrite = 1'b1; d.aluMode = ALU_SUB; end
            OP_JZ:    d.jump = J_Z;
            OP_JNZ:   d.jump = J_NZ;
            OP_JGT:   d.jump = J_GT;
            OP_JLT:   d.jump = J_LT;
            OP_JMP:   d.jump = J_ALWAYS;
            OP_HALT:  d.halt = 1'b1;
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seq_accum_if.sv
// seq_accum_if: instruction-fetch and data-memory req/ack buses of the accumulator core.
interface seq_accum_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int OP_W   = 8
);
    logic                   iReq;
    logic [ADDR_W-1:0]      iAddr;
    logic [OP_W+ADDR_W-1:0] iData;
    logic                   iAck;
    logic                   dReq;
    logic                   dWe;
    logic [ADDR_W-1:0]      dAddr;
    logic [DATA_W-1:0]      dWdata;
    logic [DATA_W-1:0]      dRdata;
    logic                   dAck;

    modport master (
        output iReq, iAddr, dReq, dWe, dAddr, dWdata,
        input  iData, iAck, dRdata, dAck
    );

    modport slave (
        input  iReq, iAddr, dReq, dWe, dAddr, dWdata,
        output iData, iAck, dRdata, dAck
    );
endinterface

// File: rtl/seq_accum_alu.sv
// seq_accum_alu: combinational pass/add/sub with zero and sign flags.
module seq_accum_alu
    import seq_accum_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  aluMode_t          mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              neg
);
    always_comb begin
        result = mode == ALU_ADD ? a + b : mode == ALU_SUB ? a - b : b;
        zero   = result == '0;
        neg    = result[DATA_W-1];
    end
endmodule

// File: rtl/seq_accum_core.sv
// seq_accum_core: multi-cycle accumulator CPU with fetch/exec/mem FSM over req/ack buses.
module seq_accum_core
    import seq_accum_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int OP_W   = 8
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              run,
    seq_accum_if.master       bus,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);
    localparam int INSTR_W = OP_W + ADDR_W;

    state_t              state, nextState;
    logic [INSTR_W-1:0]  instr;
    logic [ADDR_W-1:0]   ir, ea;
    logic [OP_W-1:0]     opField;
    logic                zFlag, nFlag;
    decode_t             dec;
    logic                legal, taken, accLoad, aluZero, aluNeg;
    logic [DATA_W-1:0]   aluB, aluResult;

    assign opField = instr[INSTR_W-1 -: OP_W];
    assign dec     = decodeOp(8'(opField));
    // opcodes wider than the defined 8-bit set are undefined, not aliased
    assign legal   = dec.legal && ((opField >> 8) == '0);
    assign ea      = instr[ADDR_W-1:0] + ir;
    assign aluB    = dec.memOp ? bus.dRdata : DATA_W'(ea);
    assign accLoad = legal && dec.accWrite &&
                     ((state == EXEC && !dec.memOp) || (state == MEM && bus.dAck));

    seq_accum_alu #(.DATA_W(DATA_W)) alu (
        .mode   (dec.aluMode),
        .a      (acc),
        .b      (aluB),
        .result (aluResult),
        .zero   (aluZero),
        .neg    (aluNeg)
    );

    always_comb begin
        taken = dec.jump == J_ALWAYS ? 1'b1 :
                dec.jump == J_Z      ? zFlag :
                dec.jump == J_NZ     ? !zFlag :
                dec.jump == J_GT     ? (!zFlag && !nFlag) :
                dec.jump == J_LT     ? nFlag : 1'b0;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = run ? FETCH : IDLE;
            FETCH:   nextState = bus.iAck ? EXEC : FETCH;
            EXEC:    nextState = (!legal || dec.halt) ? HALT : dec.memOp ? MEM : run ? FETCH : IDLE;
            MEM:     nextState = !bus.dAck ? MEM : run ? FETCH : IDLE;
            default: nextState = HALT;
        endcase
    end

    // requests decode straight from state so an async reset drops them at once
    always_comb begin
        bus.iReq = state == FETCH;
        bus.dReq = state == MEM;
        bus.dWe  = state == MEM && dec.memWrite;
    end

    assign bus.iAddr  = pc;
    assign bus.dAddr  = ea;
    assign bus.dWdata = acc;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            instr   <= '0;
            acc     <= '0;
            pc      <= '0;
            ir      <= '0;
            zFlag   <= 1'b0;
            nFlag   <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            if (state == FETCH && bus.iAck)
                instr <= bus.iData;
            if (accLoad) begin
                acc   <= aluResult;
                zFlag <= aluZero;
                nFlag <= aluNeg;
            end
            if (state == EXEC && legal && dec.irWrite)
                ir <= ADDR_W'(acc);
            if (state == EXEC && (!legal || dec.halt)) begin
                halted  <= 1'b1;
                illegal <= !legal;
            end
            if (state == EXEC && legal && !dec.halt && !dec.memOp)
                pc <= taken ? ea : pc + ADDR_W'(1);
            if (state == MEM && bus.dAck)
                pc <= pc + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_seq_accum_core.sv
// tb_seq_accum_core: directed programs against a zero/programmable-wait memory model.
module tb_seq_accum_core;
    logic        clock = 1'b0;
    logic        resetN;
    logic        run;
    logic [15:0] acc, pc;
    logic        halted, illegal;
    logic [23:0] imem [256];
    logic [15:0] dmem [256];
    int          dWait;
    int          dCnt = 0;
    logic [15:0] lastWAddr, lastWData, lastRAddr;
    int          total = 0;
    int          bad = 0;
    int          cycles;

    seq_accum_if #(.DATA_W(16), .ADDR_W(16), .OP_W(8)) bus ();

    seq_accum_core #(.DATA_W(16), .ADDR_W(16), .OP_W(8)) dut (
        .clock   (clock),
        .resetN  (resetN),
        .run     (run),
        .bus     (bus),
        .acc     (acc),
        .pc      (pc),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clock = ~clock;

    assign bus.iAck   = bus.iReq;
    assign bus.iData  = imem[bus.iAddr[7:0]];
    assign bus.dRdata = dmem[bus.dAddr[7:0]];
    assign bus.dAck   = bus.dReq && (dCnt >= dWait);

    always @(posedge clock) begin
        dCnt <= (bus.dReq && !bus.dAck) ? dCnt + 1 : 0;
        if (bus.dReq && bus.dAck && bus.dWe) begin
            lastWAddr <= bus.dAddr;
            lastWData <= bus.dWdata;
        end
        if (bus.dReq && bus.dAck && !bus.dWe)
            lastRAddr <= bus.dAddr;
    end

    function automatic logic [23:0] ins(input logic [7:0] op, input logic [15:0] opr);
        return {op, opr};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 24'hFF0000;
            dmem[i] = 16'h0000;
        end
    endtask

    task automatic restart();
        resetN = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
    endtask

    task automatic runUntilHalt(output int n);
        n = 0;
        while (!halted && n < 300) begin
            tick();
            n++;
        end
        check("halt_timeout", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        resetN = 1'b0;
        run    = 1'b0;
        dWait  = 0;
        clearMem();
        #12;
        check("rst_acc", {16'd0, acc}, 32'd0);
        check("rst_pc", {16'd0, pc}, 32'd0);
        check("rst_flags", {28'd0, halted, illegal, bus.iReq, bus.dReq}, 32'd0);
        check("rst_dwe", {31'd0, bus.dWe}, 32'd0);

        // ldi 5; addi 3; halt: halted six cycles after the first fetch
        imem[0] = ins(8'h15, 16'd5);
        imem[1] = ins(8'h25, 16'd3);
        run = 1'b1;
        restart();
        tick();
        check("t1_fetch_req", {31'd0, bus.iReq}, 32'd1);
        check("t1_fetch_addr", {16'd0, bus.iAddr}, 32'd0);
        repeat (5) tick();
        check("t1_not_yet_halted", {31'd0, halted}, 32'd0);
        tick();
        check("t1_halted", {31'd0, halted}, 32'd1);
        check("t1_acc", {16'd0, acc}, 32'd8);
        check("t1_pc", {16'd0, pc}, 32'd2);
        check("t1_illegal", {31'd0, illegal}, 32'd0);
        check("t1_ireq_off", {31'd0, bus.iReq}, 32'd0);

        // ldi 0; subi 1; jlt 7
        clearMem();
        imem[0] = ins(8'h15, 16'd0);
        imem[1] = ins(8'h35, 16'd1);
        imem[2] = ins(8'hF3, 16'd7);
        restart();
        runUntilHalt(cycles);
        check("t2_acc", {16'd0, acc}, 32'h0000FFFF);
        check("t2_pc", {16'd0, pc}, 32'd7);

        // countdown loop: ldi 3; subi 1; jnz 1; halt
        clearMem();
        imem[0] = ins(8'h15, 16'd3);
        imem[1] = ins(8'h35, 16'd1);
        imem[2] = ins(8'hF1, 16'd1);
        restart();
        runUntilHalt(cycles);
        check("t3_acc", {16'd0, acc}, 32'd0);
        check("t3_pc", {16'd0, pc}, 32'd3);
        check("t3_cycles", cycles, 32'd17);

        // indexed load and store through ir
        clearMem();
        imem[0] = ins(8'h15, 16'd4);
        imem[1] = ins(8'h02, 16'd0);
        imem[2] = ins(8'h11, 16'd100);
        imem[3] = ins(8'h00, 16'd10);
        dmem[104] = 16'h0055;
        restart();
        runUntilHalt(cycles);
        check("t4_read_addr", {16'd0, lastRAddr}, 32'd104);
        check("t4_acc", {16'd0, acc}, 32'h55);
        check("t4_write_addr", {16'd0, lastWAddr}, 32'd14);
        check("t4_write_data", {16'd0, lastWData}, 32'h55);
        check("t4_pc", {16'd0, pc}, 32'd4);
        check("t4_cycles", cycles, 32'd13);

        // jgt taken, jz not taken, jnz taken, jmp
        clearMem();
        imem[0] = ins(8'h15, 16'd2);
        imem[1] = ins(8'hF2, 16'd5);
        imem[5] = ins(8'hF0, 16'd9);
        imem[6] = ins(8'hF1, 16'd8);
        imem[8] = ins(8'hFE, 16'h20);
        restart();
        runUntilHalt(cycles);
        check("t5_pc", {16'd0, pc}, 32'h20);

        // load with three wait states
        clearMem();
        imem[0] = ins(8'h11, 16'd20);
        dmem[20] = 16'h1234;
        dWait = 3;
        restart();
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            check("t6_dreq_held", {31'd0, bus.dReq}, 32'd1);
            check("t6_daddr_held", {16'd0, bus.dAddr}, 32'd20);
            check("t6_acc_before", {16'd0, acc}, 32'd0);
            tick();
        end
        check("t6_dreq_drop", {31'd0, bus.dReq}, 32'd0);
        check("t6_acc", {16'd0, acc}, 32'h1234);
        check("t6_pc", {16'd0, pc}, 32'd1);
        runUntilHalt(cycles);
        check("t6_acc_final", {16'd0, acc}, 32'h1234);

        // async reset while a load is waiting
        clearMem();
        imem[0] = ins(8'h15, 16'd9);
        imem[1] = ins(8'h11, 16'd20);
        dWait = 5;
        restart();
        repeat (5) tick();
        check("t7_in_mem", {31'd0, bus.dReq}, 32'd1);
        check("t7_acc_pre", {16'd0, acc}, 32'd9);
        #2 resetN = 1'b0;
        #1;
        check("t7_dreq_async", {31'd0, bus.dReq}, 32'd0);
        check("t7_acc_zero", {16'd0, acc}, 32'd0);
        check("t7_pc_zero", {16'd0, pc}, 32'd0);
        check("t7_misc_zero", {29'd0, bus.iReq, bus.dWe, halted}, 32'd0);
        repeat (3) tick();
        dWait = 0;

        // undefined opcode traps with acc kept
        clearMem();
        imem[0] = ins(8'h15, 16'h42);
        imem[1] = ins(8'h77, 16'd0);
        restart();
        runUntilHalt(cycles);
        check("t8_illegal", {31'd0, illegal}, 32'd1);
        check("t8_acc", {16'd0, acc}, 32'h42);
        check("t8_pc", {16'd0, pc}, 32'd1);
        repeat (3) tick();
        check("t8_sticky", {15'd0, halted, pc}, 32'h00010001);

        // run control: idle until run, then stop after current instruction
        clearMem();
        imem[0] = ins(8'h15, 16'd7);
        run = 1'b0;
        restart();
        repeat (3) tick();
        check("t9_idle_noreq", {31'd0, bus.iReq}, 32'd0);
        run = 1'b1;
        tick();
        check("t9_fetch", {31'd0, bus.iReq}, 32'd1);
        run = 1'b0;
        tick();
        tick();
        check("t9_acc", {16'd0, acc}, 32'd7);
        check("t9_pc", {16'd0, pc}, 32'd1);
        tick();
        check("t9_stays_idle", {31'd0, bus.iReq}, 32'd0);
        run = 1'b1;
        runUntilHalt(cycles);
        check("t9_resume_pc", {16'd0, pc}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
